// File: rtl/pilha_hw.sv
// pilha_hw: hardware LIFO return/data stack.
// The control FSM holds push/pop as levels. Each rising edge of a level
// is one stack operation. data_out is a registered copy of the top of stack.
// Optional build macro: STACK_WRAP_EN. When it is defined, a push while full
// overwrites the oldest entry instead of being rejected.
module pilha_hw #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    sp;
  logic             push_d, pop_d;
  logic             push_ev, pop_ev;

  logic [AW-1:0]    sp_m1, sp_m2;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    sp_n;
  logic [AW:0]      cnt_n;
  logic [WIDTH-1:0] dout_n;
  logic             ovf_set, unf_set;

  assign push_ev = push & ~push_d;
  assign pop_ev  = pop & ~pop_d;
  assign sp_m1   = sp - AW'(1);
  assign sp_m2   = sp - AW'(2);
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));

  // Decode the edge events into next sp/count/top and a single memory write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sp;
    sp_n    = sp;
    cnt_n   = count;
    dout_n  = data_out;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (push_ev && pop_ev && !empty) begin
      // Simultaneous push and pop replace the top in place.
      wr_en   = 1'b1;
      wr_addr = sp_m1;
      dout_n  = data_in;
    end else if (push_ev) begin
      // This branch also handles push+pop on an empty stack as a plain push.
      if (!full) begin
        wr_en  = 1'b1;
        sp_n   = sp + AW'(1);
        cnt_n  = count + (AW+1)'(1);
        dout_n = data_in;
      end else begin
        ovf_set = 1'b1;
`ifdef STACK_WRAP_EN
        // Circular mode: the new word overwrites the oldest slot, and count stays at DEPTH.
        wr_en  = 1'b1;
        sp_n   = sp + AW'(1);
        dout_n = data_in;
`endif
      end
    end else if (pop_ev) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        sp_n   = sp_m1;
        cnt_n  = count - (AW+1)'(1);
        dout_n = (count == (AW+1)'(1)) ? '0 : mem[sp_m2];
      end
    end
  end

  // Storage array has no reset. Writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_addr] <= data_in;
  end

  // Control state, registered top of stack, and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= '0;
      count     <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      push_d    <= 1'b0;
      pop_d     <= 1'b0;
    end else begin
      push_d    <= push;
      pop_d     <= pop;
      sp        <= sp_n;
      count     <= cnt_n;
      data_out  <= dout_n;
      // A new error in the same cycle as err_clr takes priority over the clear.
      overflow  <= ovf_set | (overflow  & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_pilha_hw.sv
// Directed bench for pilha_hw.
// A table of one-cycle vectors is followed by a hand-written fill/overflow/drain sequence.
module tb_pilha_hw;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             reset, push, pop, err_clr;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [AW:0]      count;
  logic             empty, full, overflow, underflow;

  int n_vec = 0;
  int n_bad = 0;

  pilha_hw #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .err_clr(err_clr), .data_out(data_out), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, psh, pp, clr;
    logic [31:0] din;
    logic [4:0]  cnt;
    logic [31:0] dout;
    logic        ovf, unf;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string name, logic rst, logic psh, logic pp, logic clr,
                              logic [31:0] din, logic [4:0] cnt, logic [31:0] dout,
                              logic ovf, logic unf);
    vec_t v;
    v.name = name; v.rst = rst; v.psh = psh; v.pp = pp; v.clr = clr; v.din = din;
    v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endfunction

  // Apply the inputs for one clock edge and sample the outputs 1 time unit after the edge.
  task automatic step(logic rst, logic psh, logic pp, logic clr, logic [31:0] din);
    @(negedge clk);
    reset = rst; push = psh; pop = pp; err_clr = clr; data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [4:0] cnt, logic [31:0] dout, logic ovf, logic unf);
    logic e, f;
    e = (cnt == 5'd0);
    f = (cnt == 5'(DEPTH));
    n_vec++;
    if (count !== cnt || data_out !== dout || overflow !== ovf || underflow !== unf ||
        empty !== e || full !== f) begin
      n_bad++;
      $display("FAIL %s: got cnt=%0d dout=%h ovf=%b unf=%b emp=%b full=%b, want cnt=%0d dout=%h ovf=%b unf=%b emp=%b full=%b",
               name, count, data_out, overflow, underflow, empty, full, cnt, dout, ovf, unf, e, f);
    end
  endtask

  initial begin
    logic [31:0] exp_top;
    reset = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; data_in = '0;

    add("reset",      1,0,0,0, 32'h0,  0, 32'h0,  0,0);
    add("push10",     0,1,0,0, 32'h10, 1, 32'h10, 0,0);
    add("idle",       0,0,0,0, 32'h0,  1, 32'h10, 0,0);
    add("push20",     0,1,0,0, 32'h20, 2, 32'h20, 0,0);
    add("idle",       0,0,0,0, 32'h0,  2, 32'h20, 0,0);
    add("push30",     0,1,0,0, 32'h30, 3, 32'h30, 0,0);
    add("idle",       0,0,0,0, 32'h0,  3, 32'h30, 0,0);
    add("pop1",       0,0,1,0, 32'h0,  2, 32'h20, 0,0);
    add("idle",       0,0,0,0, 32'h0,  2, 32'h20, 0,0);
    add("pop2",       0,0,1,0, 32'h0,  1, 32'h10, 0,0);
    add("idle",       0,0,0,0, 32'h0,  1, 32'h10, 0,0);
    add("pop3",       0,0,1,0, 32'h0,  0, 32'h0,  0,0);
    add("idle",       0,0,0,0, 32'h0,  0, 32'h0,  0,0);
    for (int i = 0; i < 5; i++)
      add("hold_push",0,1,0,0, 32'hAA, 1, 32'hAA, 0,0);
    add("idle",       0,0,0,0, 32'h0,  1, 32'hAA, 0,0);
    add("pop_aa",     0,0,1,0, 32'h0,  0, 32'h0,  0,0);
    add("idle",       0,0,0,0, 32'h0,  0, 32'h0,  0,0);
    add("pop_empty",  0,0,1,0, 32'h0,  0, 32'h0,  0,1);
    add("unf_sticky", 0,0,0,0, 32'h0,  0, 32'h0,  0,1);
    add("err_clr",    0,0,0,1, 32'h0,  0, 32'h0,  0,0);
    add("clr_vs_err", 0,0,1,1, 32'h0,  0, 32'h0,  0,1);
    add("idle",       0,0,0,0, 32'h0,  0, 32'h0,  0,1);
    add("err_clr2",   0,0,0,1, 32'h0,  0, 32'h0,  0,0);
    add("push5",      0,1,0,0, 32'h5,  1, 32'h5,  0,0);
    add("idle",       0,0,0,0, 32'h0,  1, 32'h5,  0,0);
    add("push7",      0,1,0,0, 32'h7,  2, 32'h7,  0,0);
    add("idle",       0,0,0,0, 32'h0,  2, 32'h7,  0,0);
    add("replace",    0,1,1,0, 32'h42, 2, 32'h42, 0,0);
    add("idle",       0,0,0,0, 32'h0,  2, 32'h42, 0,0);
    add("pop_repl",   0,0,1,0, 32'h0,  1, 32'h5,  0,0);
    add("idle",       0,0,0,0, 32'h0,  1, 32'h5,  0,0);
    add("pop5",       0,0,1,0, 32'h0,  0, 32'h0,  0,0);
    add("idle",       0,0,0,0, 32'h0,  0, 32'h0,  0,0);
    add("both_empty", 0,1,1,0, 32'h66, 1, 32'h66, 0,0);
    add("idle",       0,0,0,0, 32'h0,  1, 32'h66, 0,0);
    add("pop66",      0,0,1,0, 32'h0,  0, 32'h0,  0,0);
    add("pop_held",   0,0,1,0, 32'h0,  0, 32'h0,  0,0);
    add("push_vs_hold",0,1,1,0,32'h9,  1, 32'h9,  0,0);
    add("hold_both",  0,1,1,0, 32'h9,  1, 32'h9,  0,0);
    add("idle",       0,0,0,0, 32'h0,  1, 32'h9,  0,0);
    add("pop9",       0,0,1,0, 32'h0,  0, 32'h0,  0,0);
    add("idle",       0,0,0,0, 32'h0,  0, 32'h0,  0,0);
    add("push_in_rst",1,1,0,0, 32'h3,  0, 32'h0,  0,0);
    add("push_after", 0,1,0,0, 32'h3,  1, 32'h3,  0,0);
    add("idle",       0,0,0,0, 32'h0,  1, 32'h3,  0,0);
    add("reset2",     1,0,0,0, 32'h0,  0, 32'h0,  0,0);
    add("idle",       0,0,0,0, 32'h0,  0, 32'h0,  0,0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].psh, tbl[i].pp, tbl[i].clr, tbl[i].din);
      chk(tbl[i].name, tbl[i].cnt, tbl[i].dout, tbl[i].ovf, tbl[i].unf);
    end

    // Fill the stack with 1..DEPTH, then push once more while full.
    for (int i = 1; i <= DEPTH; i++) begin
      step(0,1,0,0, 32'(i));
      step(0,0,0,0, 32'h0);
    end
    chk("filled", 5'(DEPTH), 32'(DEPTH), 0, 0);
    step(0,1,0,0, 32'h99);
`ifdef STACK_WRAP_EN
    chk("push_full_wrap", 5'(DEPTH), 32'h99, 1, 0);
`else
    chk("push_full", 5'(DEPTH), 32'(DEPTH), 1, 0);
`endif
    step(0,0,0,0, 32'h0);

    // Drain the stack. data_out before each pop is the word the pop consumes.
    for (int i = 0; i < DEPTH; i++) begin
`ifdef STACK_WRAP_EN
      exp_top = (i == 0) ? 32'h99 : 32'(DEPTH - i + 1);
`else
      exp_top = 32'(DEPTH - i);
`endif
      chk("drain_top", 5'(DEPTH - i), exp_top, 1, 0);
      step(0,0,1,0, 32'h0);
      step(0,0,0,0, 32'h0);
    end
    chk("drained", 0, 32'h0, 1, 0);
    step(0,0,1,0, 32'h0);
    chk("pop_after_drain", 0, 32'h0, 1, 1);
    step(0,0,0,1, 32'h0);
    chk("clr_both", 0, 32'h0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pilha_hw.md
Name: pilha_hw

Overview:
- Hardware LIFO return/data stack driven by the control unit's `push`/`pop` strobes.
- Sits directly downstream of the control FSM:
  - `jal` pushes the return PC.
  - `jst` pops into the PC mux.
  - `lstk` pushes a bank value; `sstk` pops it for a memory write.
- Converts level-held control strobes into single operations.
- Exposes top-of-stack, occupancy and sticky error flags.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 16, number of entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived, do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- push  in  1  push request; level from the control FSM, may stay high several cycles.
- pop  in  1  pop request; level, may stay high several cycles (e.g. while waiting on enter).
- data_in  in  WIDTH  word to push (muxed PC+1 or bank value).
- err_clr  in  1  clears the sticky error flags.
- data_out  out  WIDTH  current top-of-stack; 0 when empty.
- count  out  AW+1  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: push rejected while full.
- underflow  out  1  sticky: pop while empty.

Behaviour:
- Reset (clk edge with reset=1):
  - sp=0, count=0, data_out=0, empty=1, full=0.
  - overflow=0, underflow=0, push_d=0, pop_d=0.
  - Array contents are not cleared.
  - Reset has priority over every operation in the same cycle.
- Edge detection:
  - push_d/pop_d register the previous-cycle levels.
  - push_ev = push & ~push_d; pop_ev = pop & ~pop_d.
  - Exactly one operation per assertion, however long the level is held.
  - A request already high in the first cycle after reset counts as an event.
- Storage:
  - Array mem[DEPTH]; sp points to the next free slot; top = mem[sp-1].
  - data_out is a registered copy of top, updated on the same edge as the operation.
  - data_out is valid the cycle after the event edge.
  - Before the edge, data_out holds the old top. A consumer sampling on the event edge (jst loading PC) therefore gets the pre-pop top.
- Operations on posedge:
  - push_ev only, not full: mem[sp]<=data_in; sp<=sp+1; count+1; data_out<=data_in.
  - pop_ev only, not empty: sp<=sp-1; count-1; data_out<=mem[sp-2], or 0 if count becomes 0.
  - push_ev and pop_ev together, not empty: replace top. mem[sp-1]<=data_in; sp and count unchanged; data_out<=data_in.
  - push_ev and pop_ev together, empty: treated as a plain push; underflow not set.
  - pop_ev while empty: no state change; underflow<=1.
  - push_ev while full: no state change; overflow<=1 (without STACK_WRAP_EN).
  - A push edge while pop is held high with no pop edge is a plain push, and vice versa.
- Flags:
  - empty and full are combinational from count.
  - overflow and underflow remain set until err_clr.
  - If err_clr and a new error occur in the same cycle, the error wins (flag set).
- Arithmetic:
  - sp wraps modulo DEPTH (AW bits).
  - count never exceeds DEPTH and never drops below 0.
- Mid-operation:
  - No multi-cycle operations exist.
  - Reset asserted while push or pop is high discards the event.
  - After reset release, a still-high level counts as a new event (push_d was cleared).

Optional Feature:
- Macro: STACK_WRAP_EN.
- Defined: push_ev while full overwrites the oldest entry (circular buffer).
  - mem[sp]<=data_in; sp<=sp+1; count stays DEPTH; data_out<=data_in.
  - overflow is still set, as a lost-entry indication.
  - Subsequent pops return the DEPTH most recent entries, then underflow.
- Not defined: a full push is rejected, the stack is unchanged, and overflow is set.

Test Plan:
- Reset, then push 0x10, 0x20, 0x30 as one-cycle pulses -> count=3, data_out=0x30; three pops -> data_out 0x20, 0x10, 0, empty=1.
- Hold push high 5 cycles with data_in=0xAA -> exactly one entry: count=1, data_out=0xAA.
- Pop on an empty stack -> count=0, underflow=1 sticky; err_clr pulse -> underflow=0; err_clr coincident with another empty pop -> underflow stays 1.
- Fill DEPTH=16 with values 1..16, then push 0x99:
  - Without STACK_WRAP_EN -> count=16, data_out=16, overflow=1; 16 pops return 16..1.
  - With STACK_WRAP_EN -> data_out=0x99, overflow=1; 16 pops return 0x99, 16..2.
- Stack holding 0x5 and 0x7, push and pop rising together with data_in=0x42 -> count=2, data_out=0x42; pop -> data_out=0x5.
- Push 0x3 with reset asserted in the same cycle -> count=0, data_out=0; push still high after reset release -> count=1, data_out=data_in.
